conv2x2_stream: RTL and testbench
=================================

Name: conv2x2_stream

Overview:
- Streaming 2x2 stride-1 convolution stage, fed by the filter weight memory. Takes 4 weights + bias from it; receives image pixels row-major, one per valid cycle.
- Emits one filtered feature-map pixel per complete 2x2 window (IMG_H-1 x IMG_W-1 outputs), signed fixed point.
- Sits between the image source / weight memory and the downstream pooling/activation stage.

Parameters:
- dataWidth, 16: pixel, weight, bias and output width; signed two's complement.
- IMG_W, 28: image width in pixels (>=2).
- IMG_H, 28: image height in pixels (>=2).
- FRAC_BITS, 8: fractional bits of the shared Q format.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- w_en  out  1  read enable to the weight memory.
- w0, w1, w2, w3  in  dataWidth each  weights: top-left, top-right, bottom-left, bottom-right.
- bias  in  dataWidth  filter bias.
- in_valid  in  1  pixel strobe.
- in_pixel  in  dataWidth  input pixel.
- out_valid  out  1  result strobe.
- out_pixel  out  dataWidth  convolution result.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last output.

Behaviour:
- Reset (async, any state, incl. mid-frame): state IDLE; all counters and pipeline valids 0; w_en, out_valid, busy, done = 0; out_pixel = 0; weight registers 0. Line buffer contents need not be cleared.
- FSM:
  - IDLE: start -> LOAD.
  - LOAD: w_en=1 for exactly one cycle -> LATCH.
  - LATCH: capture w0..w3 and bias into internal registers (memory output valid this cycle); clear row/col counters -> RUN.
  - RUN: when the last pixel (row IMG_H-1, col IMG_W-1) is accepted -> DRAIN.
  - DRAIN: wait until the pipeline is empty; pulse done -> IDLE.
- busy = 1 in LOAD, LATCH, RUN and DRAIN.
- start outside IDLE is ignored.
- in_valid outside RUN is ignored; no pixel is stored.
- Pixel acceptance (RUN and in_valid):
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - Line buffer (IMG_W entries) holds the previous row. Entry [col] is read before it is overwritten with in_pixel.
  - prev register holds the last pixel of the current row.
- Window forms when row>=1 and col>=1: TL=line[col-1], TR=line[col], BL=prev, BR=in_pixel. No window at row 0 or col 0.
- Gaps in in_valid are allowed; the pipeline carries per-stage valid bits, and idle cycles produce no output.
- Stage 1 (registered): four signed products, each 2*dataWidth bits.
- Stage 2 (registered):
  - acc = sum of products + (bias <<< FRAC_BITS), 2*dataWidth+3 bits.
  - r = acc >>> FRAC_BITS (arithmetic shift, truncating).
  - Saturate r to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
- Latency: out_valid asserts exactly 2 cycles after the accepting edge of the window's BR pixel.
- out_pixel holds its value while out_valid=0.
- Output count per frame = (IMG_H-1)*(IMG_W-1), in row-major window order.
- done pulses the cycle after the final out_valid; busy drops with done.
- start arriving on the done cycle is ignored; start is accepted from the next IDLE cycle.

Optional Feature:
- Macro CONV2X2_RELU_EN.
- Defined: stage 2 clamps negative saturated results to 0 (ReLU); latency unchanged.
- Undefined: signed saturated result passes through unchanged.

Test Plan:
- Basic frame: IMG_W=IMG_H=3, FRAC_BITS=8; weights all 256 (1.0), bias 0; pixels k*256 for k=1..9 streamed with no gaps -> exactly 4 outputs: 3072, 4096, 6144, 7168, each 2 cycles after pixels 5, 6, 8, 9; then done pulse, busy low.
- Bias and gaps: same frame, bias=256, random 0-3 idle cycles between pixels -> outputs 3328, 4352, 6400, 7424, unchanged by the gaps; in_valid before start produces nothing.
- Saturation: all pixels 32767, weights 1024 (4.0) -> every output 32767. Pixels -32768, same weights -> every output -32768.
- Negative / ReLU: basic frame with weights -256 -> outputs -3072, -4096, -6144, -7168 without the macro; all 0 with CONV2X2_RELU_EN.
- Weight handshake: start pulse -> w_en high for exactly one cycle, 1 cycle after start. Weights changed during RUN have no effect on the frame's results. A second start during RUN is ignored.
- Reset mid-frame: assert rst after 5 pixels of a 28x28 frame -> out_valid, busy, done immediately 0. A new start plus a full 28x28 frame yields exactly 729 outputs.

Source files
------------

// File: rtl/conv2x2_stream.sv
// Streaming 2x2 stride-1 convolution: line buffer, four-multiply stage, then a saturating accumulate stage.
// Optional feature: define CONV2X2_RELU_EN to clamp negative results to zero.
module conv2x2_stream #(
    parameter int dataWidth = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int FRAC_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        w_en,
    input  logic signed [dataWidth-1:0] w0,
    input  logic signed [dataWidth-1:0] w1,
    input  logic signed [dataWidth-1:0] w2,
    input  logic signed [dataWidth-1:0] w3,
    input  logic signed [dataWidth-1:0] bias,
    input  logic                        in_valid,
    input  logic signed [dataWidth-1:0] in_pixel,
    output logic                        out_valid,
    output logic signed [dataWidth-1:0] out_pixel,
    output logic                        busy,
    output logic                        done
);

    localparam int P_W   = 2 * dataWidth;
    localparam int ACC_W = 2 * dataWidth + 3;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0]         COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]         ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'((64'sd1 <<< (dataWidth - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, LOAD, LATCH, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic signed [dataWidth-1:0] line_buf [IMG_W];
    logic signed [dataWidth-1:0] line_rd;
    logic signed [dataWidth-1:0] prev_pix;
    logic signed [dataWidth-1:0] top_prev;
    logic signed [dataWidth-1:0] w_r [4];
    logic signed [dataWidth-1:0] bias_r;

    logic accept, last_pix, win_ok;

    logic                    s1_valid;
    logic signed [P_W-1:0]   prod [4];
    logic signed [ACC_W-1:0] acc, shifted;
    logic signed [dataWidth-1:0] sat_val;

    assign accept   = (state == RUN) && in_valid;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    assign win_ok   = accept && (row != '0) && (col != '0);
    assign line_rd  = line_buf[col];
    assign busy     = (state != IDLE);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        w_en       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD: begin
                w_en       = 1'b1;
                state_next = LATCH;
            end
            LATCH:   state_next = RUN;
            RUN:     if (accept && last_pix) state_next = DRAIN;
            DRAIN: begin
                if (!s1_valid && !out_valid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state and pipeline registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            prev_pix  <= '0;
            top_prev  <= '0;
            w_r       <= '{default: '0};
            bias_r    <= '0;
            s1_valid  <= 1'b0;
            prod      <= '{default: '0};
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else begin
            state <= state_next;
            if (state == LATCH) begin
                w_r[0] <= w0;
                w_r[1] <= w1;
                w_r[2] <= w2;
                w_r[3] <= w3;
                bias_r <= bias;
                row    <= '0;
                col    <= '0;
            end else if (accept) begin
                prev_pix <= in_pixel;
                // Old line[col] becomes the next window's top-left once line[col] is overwritten.
                top_prev <= line_rd;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            s1_valid <= win_ok;
            if (win_ok) begin
                prod[0] <= P_W'(top_prev) * P_W'(w_r[0]);
                prod[1] <= P_W'(line_rd)  * P_W'(w_r[1]);
                prod[2] <= P_W'(prev_pix) * P_W'(w_r[2]);
                prod[3] <= P_W'(in_pixel) * P_W'(w_r[3]);
            end

            out_valid <= s1_valid;
            if (s1_valid) out_pixel <= sat_val;
        end
    end

    // NOTE: the line buffer has no reset; row 0 of every frame overwrites it before any window reads it.
    always_ff @(posedge clk) begin
        if (accept) line_buf[col] <= in_pixel;
    end

    always_comb begin
        acc = ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2]) + ACC_W'(prod[3])
            + (ACC_W'(bias_r) <<< FRAC_BITS);
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            sat_val = {1'b0, {(dataWidth-1){1'b1}}};
        else if (shifted < SAT_MIN)
            sat_val = {1'b1, {(dataWidth-1){1'b0}}};
        else
            sat_val = shifted[dataWidth-1:0];
`ifdef CONV2X2_RELU_EN
        if (sat_val[dataWidth-1]) sat_val = '0;
`endif
    end

endmodule

// File: tb/tb_conv2x2_stream.sv
// Directed bench for conv2x2_stream: a 3x3 instance for function/timing and a 28x28 instance for reset and full-frame count.
module tb_conv2x2_stream;

    localparam int DW = 16;
    localparam int BR[4] = '{4, 5, 7, 8};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    logic signed [DW-1:0] mem_w [4];
    logic signed [DW-1:0] mem_b;
    logic signed [DW-1:0] w0, w1, w2, w3, bias;

    logic                 s_start = 1'b0, s_in_valid = 1'b0;
    logic signed [DW-1:0] s_in_pixel = '0;
    logic                 s_w_en, s_out_valid, s_busy, s_done;
    logic signed [DW-1:0] s_out_pixel;

    logic                 b_start = 1'b0, b_in_valid = 1'b0;
    logic signed [DW-1:0] b_in_pixel = '0;
    logic                 b_w_en, b_out_valid, b_busy, b_done;
    logic signed [DW-1:0] b_out_pixel;

    conv2x2_stream #(.dataWidth(DW), .IMG_W(3), .IMG_H(3), .FRAC_BITS(8)) dut (
        .clk(clk), .rst(rst), .start(s_start), .w_en(s_w_en),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .bias(bias),
        .in_valid(s_in_valid), .in_pixel(s_in_pixel),
        .out_valid(s_out_valid), .out_pixel(s_out_pixel), .busy(s_busy), .done(s_done)
    );

    conv2x2_stream #(.dataWidth(DW), .IMG_W(28), .IMG_H(28), .FRAC_BITS(8)) dut_big (
        .clk(clk), .rst(rst), .start(b_start), .w_en(b_w_en),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .bias(bias),
        .in_valid(b_in_valid), .in_pixel(b_in_pixel),
        .out_valid(b_out_valid), .out_pixel(b_out_pixel), .busy(b_busy), .done(b_done)
    );

    // Weight memory: contents are valid only in the cycle after w_en, junk otherwise.
    always @(posedge clk) begin
        if (s_w_en || b_w_en) begin
            w0 <= mem_w[0]; w1 <= mem_w[1]; w2 <= mem_w[2]; w3 <= mem_w[3]; bias <= mem_b;
        end else begin
            w0 <= DW'($urandom); w1 <= DW'($urandom); w2 <= DW'($urandom);
            w3 <= DW'($urandom); bias <= DW'($urandom);
        end
    end

    logic signed [DW-1:0] ov_q[$];
    int oc_q[$];
    int acc_q[$];
    int wen_cnt = 0;
    int big_cnt = 0;

    always @(negedge clk) begin
        if (s_out_valid) begin
            ov_q.push_back(s_out_pixel);
            oc_q.push_back(cyc);
        end
        if (s_w_en) wen_cnt++;
        if (b_out_valid) big_cnt++;
    end

    task automatic set_mem(input int w, input int b);
        for (int i = 0; i < 4; i++) mem_w[i] = DW'(w);
        mem_b = DW'(b);
    endtask

    // Pulse start on the small instance and return at the first RUN-cycle negedge.
    task automatic start_small();
        ov_q.delete(); oc_q.delete(); acc_q.delete();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // At pixel index inj, also pulse start and rewrite the weight memory.
    task automatic drive_small(input int pix[9], input int max_gap, input int inj);
        for (int i = 0; i < 9; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                s_in_valid = 1'b0;
                @(negedge clk);
            end
            s_in_valid = 1'b1;
            s_in_pixel = DW'(pix[i]);
            s_start    = (i == inj);
            if (i == inj) set_mem(1024, 512);
            acc_q.push_back(cyc + 1);
            @(negedge clk);
            s_start = 1'b0;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic wait_small_done(output int done_cyc, output bit seen);
        int n = 0;
        while (!s_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        seen = s_done;
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (s_busy !== 1'b0 || s_out_valid !== 1'b0 || s_done !== 1'b0 || s_w_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b out_valid=%b done=%b w_en=%b, expected all 0",
                     s_busy, s_out_valid, s_done, s_w_en);
        end
        tests_run++;
        if (s_out_pixel !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_out_pixel: got %0d, expected 0", s_out_pixel);
        end
        tests_run++;
        if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_big: busy=%b out_valid=%b, expected 0 0", b_busy, b_out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int pix[9];
        int exp_v[4] = '{3072, 4096, 6144, 7168};
        int dc;
        bit seen;
        for (int k = 0; k < 9; k++) pix[k] = (k + 1) * 256;
        set_mem(256, 0);
        start_small();
        drive_small(pix, 0, -1);
        wait_small_done(dc, seen);
        tests_run++;
        if (ov_q.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d outputs, expected 4", ov_q.size());
        end
        for (int j = 0; j < 4 && j < ov_q.size(); j++) begin
            tests_run++;
            if (ov_q[j] !== DW'(exp_v[j]) || oc_q[j] != acc_q[BR[j]] + 1) begin
                tests_failed++;
                $display("FAIL basic_out%0d: got %0d at cycle %0d, expected %0d at cycle %0d",
                         j, ov_q[j], oc_q[j], exp_v[j], acc_q[BR[j]] + 1);
            end
        end
        tests_run++;
        if (!seen || ov_q.size() == 0 || dc != oc_q[oc_q.size()-1] + 1) begin
            tests_failed++;
            $display("FAIL basic_done: seen=%0d at cycle %0d, expected one cycle after last output", seen, dc);
        end
        @(negedge clk);
        tests_run++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_out_valid !== 1'b0 || s_out_pixel !== 16'sd7168) begin
            tests_failed++;
            $display("FAIL basic_after_done: busy=%b done=%b out_valid=%b out_pixel=%0d, expected 0 0 0 7168",
                     s_busy, s_done, s_out_valid, s_out_pixel);
        end
    endtask

    task automatic test_bias_gaps();
        int pix[9];
        int exp_v[4] = '{3328, 4352, 6400, 7424};
        int dc;
        bit seen;
        ov_q.delete(); oc_q.delete();
        repeat (5) begin
            s_in_valid = 1'b1;
            s_in_pixel = 16'sd1000;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (ov_q.size() != 0 || s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_in_valid: %0d outputs busy=%b, expected 0 outputs busy=0", ov_q.size(), s_busy);
        end
        for (int k = 0; k < 9; k++) pix[k] = (k + 1) * 256;
        set_mem(256, 256);
        start_small();
        drive_small(pix, 3, -1);
        wait_small_done(dc, seen);
        tests_run++;
        if (ov_q.size() != 4 || !seen) begin
            tests_failed++;
            $display("FAIL gaps_count: got %0d outputs done=%0d, expected 4 outputs and done", ov_q.size(), seen);
        end
        for (int j = 0; j < 4 && j < ov_q.size(); j++) begin
            tests_run++;
            if (ov_q[j] !== DW'(exp_v[j]) || oc_q[j] != acc_q[BR[j]] + 1) begin
                tests_failed++;
                $display("FAIL gaps_out%0d: got %0d at cycle %0d, expected %0d at cycle %0d",
                         j, ov_q[j], oc_q[j], exp_v[j], acc_q[BR[j]] + 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int pix[9];
        int src[2] = '{32767, -32768};
        int exp_v[2] = '{32767, -32768};
        int dc;
        bit seen;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 9; k++) pix[k] = src[f];
            set_mem(1024, 0);
            start_small();
            drive_small(pix, 0, -1);
            wait_small_done(dc, seen);
            tests_run++;
            if (ov_q.size() != 4 || !seen) begin
                tests_failed++;
                $display("FAIL sat%0d_count: got %0d outputs done=%0d, expected 4 and done", f, ov_q.size(), seen);
            end
            for (int j = 0; j < ov_q.size(); j++) begin
                tests_run++;
                if (ov_q[j] !== DW'(exp_v[f])) begin
                    tests_failed++;
                    $display("FAIL sat%0d_out%0d: got %0d, expected %0d", f, j, ov_q[j], exp_v[f]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_negative();
        int pix[9];
`ifdef CONV2X2_RELU_EN
        int exp_v[4] = '{0, 0, 0, 0};
`else
        int exp_v[4] = '{-3072, -4096, -6144, -7168};
`endif
        int dc;
        bit seen;
        for (int k = 0; k < 9; k++) pix[k] = (k + 1) * 256;
        set_mem(-256, 0);
        start_small();
        drive_small(pix, 0, -1);
        wait_small_done(dc, seen);
        tests_run++;
        if (ov_q.size() != 4 || !seen) begin
            tests_failed++;
            $display("FAIL neg_count: got %0d outputs done=%0d, expected 4 and done", ov_q.size(), seen);
        end
        for (int j = 0; j < 4 && j < ov_q.size(); j++) begin
            tests_run++;
            if (ov_q[j] !== DW'(exp_v[j])) begin
                tests_failed++;
                $display("FAIL neg_out%0d: got %0d, expected %0d", j, ov_q[j], exp_v[j]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_weight_handshake();
        int pix[9];
        int exp_v[4] = '{3072, 4096, 6144, 7168};
        int wen_base;
        int dc;
        bit seen;
        for (int k = 0; k < 9; k++) pix[k] = (k + 1) * 256;
        set_mem(256, 0);
        ov_q.delete(); oc_q.delete(); acc_q.delete();
        wen_base = wen_cnt;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        tests_run++;
        if (s_w_en !== 1'b1 || s_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL hs_w_en_rise: w_en=%b busy=%b one cycle after start, expected 1 1", s_w_en, s_busy);
        end
        @(negedge clk);
        tests_run++;
        if (s_w_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL hs_w_en_width: w_en=%b two cycles after start, expected 0", s_w_en);
        end
        @(negedge clk);
        drive_small(pix, 0, 4);
        wait_small_done(dc, seen);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        tests_run++;
        if (s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hs_start_on_done: busy=%b after start on done cycle, expected 0", s_busy);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (wen_cnt - wen_base != 1 || s_busy !== 1'b0 || !seen) begin
            tests_failed++;
            $display("FAIL hs_single_load: %0d w_en cycles busy=%b done=%0d, expected 1 0 1",
                     wen_cnt - wen_base, s_busy, seen);
        end
        tests_run++;
        if (ov_q.size() != 4) begin
            tests_failed++;
            $display("FAIL hs_count: got %0d outputs, expected 4", ov_q.size());
        end
        for (int j = 0; j < 4 && j < ov_q.size(); j++) begin
            tests_run++;
            if (ov_q[j] !== DW'(exp_v[j])) begin
                tests_failed++;
                $display("FAIL hs_out%0d: got %0d, expected %0d", j, ov_q[j], exp_v[j]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int n;
        set_mem(256, 0);
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1;
            b_in_pixel = DW'(i * 100);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (b_busy !== 1'b0 || b_out_valid !== 1'b0 || b_done !== 1'b0 || b_w_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_ctrl: busy=%b out_valid=%b done=%b w_en=%b, expected all 0",
                     b_busy, b_out_valid, b_done, b_w_en);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = big_cnt;
        b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 784; i++) begin
            b_in_valid = 1'b1;
            b_in_pixel = DW'((i % 13) * 64 - 300);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        n = 0;
        while (!b_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!b_done) begin
            tests_failed++;
            $display("FAIL midrst_done: done not seen within 60 cycles, expected done pulse");
        end
        tests_run++;
        if (big_cnt - base != 729) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d outputs, expected 729", big_cnt - base);
        end
        @(negedge clk);
    endtask

    initial begin
        set_mem(0, 0);
        test_reset();
        test_basic();
        test_bias_gaps();
        test_saturation();
        test_negative();
        test_weight_handshake();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
